pe_conv_ctrl: RTL and testbench

Sequencer for the 8x8x64 3x3-convolution PE array. Steps the 9-tap kernel index that drives the window mux select and weight-line select, issues valid/op to the PE per tap, and repeats over multiple 64-channel groups. Presents the finished 8x8 result through a valid/ready handshake. Sits between the layer scheduler (start/cfg) and one PE instance plus its weight buffer.

---
 rtl/pe_pkg.sv | 36 +++
 rtl/pe_tap_counter.sv | 45 ++++
 rtl/pe_conv_ctrl.sv | 133 +++++++++++++
 tb/tb_pe_conv_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the 8x8x64 3x3-convolution PE array and its sequencer:
// op encodings, geometry, counter widths and the controller state type.
package pe_pkg;

    localparam int KTAPS      = 9;
    localparam int MAX_GROUPS = 16;
    localparam int GRP_W      = 4;
    localparam int WADDR_W    = 8;
    localparam int TAP_W      = 4;
    localparam int PE_LAT     = 1;
    localparam int DRAIN_W    = 4;

    localparam int DATA_W     = 8;
    localparam int WEIGHT_W   = 8;
    localparam int ACC_W      = 32;
    localparam int CHANNELS   = 64;
    localparam int TILE_DIM   = 8;

    localparam logic [1:0] PE_OP_LOAD = 2'b00;
    localparam logic [1:0] PE_OP_ACC  = 2'b01;

    // DRAIN counts down to zero, so it is loaded with one less than the PE latency.
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'((PE_LAT > 0) ? PE_LAT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_OUTPUT
    } state_t;

    function automatic logic [GRP_W-1:0] last_group_of(input logic [GRP_W-1:0] groups);
        return (groups == '0) ? '0 : groups - GRP_W'(1);
    endfunction

endpackage

// File: rtl/pe_tap_counter.sv
// Tap/group/weight-address counters for the convolution sequencer.
// Advances once per accepted PE beat and holds on the final beat of a job.
module pe_tap_counter
    import pe_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    input  logic [GRP_W-1:0]   last_group,
    output logic [TAP_W-1:0]   tap_idx,
    output logic [WADDR_W-1:0] weight_addr,
    output logic               first_beat,
    output logic               last_beat
);

    logic [GRP_W-1:0] group;
    logic             tap_end;

    assign tap_end    = (tap_idx == TAP_W'(KTAPS - 1));
    assign first_beat = (tap_idx == '0) && (group == '0);
    assign last_beat  = tap_end && (group == last_group);

    // The address is a plain running count, so no group*KTAPS multiply is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_idx     <= '0;
            group       <= '0;
            weight_addr <= '0;
        end else if (clear) begin
            tap_idx     <= '0;
            group       <= '0;
            weight_addr <= '0;
        end else if (advance && !last_beat) begin
            weight_addr <= weight_addr + WADDR_W'(1);
            if (tap_end) begin
                tap_idx <= '0;
                group   <= group + GRP_W'(1);
            end else begin
                tap_idx <= tap_idx + TAP_W'(1);
            end
        end
    end

endmodule

// File: rtl/pe_conv_ctrl.sv
// Convolution sequencer: steps 9 kernel taps over N channel groups, drives the PE,
// then presents the result via valid/ready. Optional counters: define PE_CTRL_PERF_EN.
module pe_conv_ctrl
    import pe_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [GRP_W-1:0]   cfg_groups,
    input  logic               data_stall,
    output logic               busy,
    output logic [TAP_W-1:0]   tap_idx,
    output logic [WADDR_W-1:0] weight_addr,
    output logic               pe_ena,
    output logic               pe_valid,
    output logic [1:0]         pe_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               done
`ifdef PE_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_busy_cycles,
    output logic [31:0]        perf_stall_cycles
`endif
);

    state_t               state;
    state_t               next_state;
    logic [GRP_W-1:0]     last_group;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 accept;
    logic                 beat;
    logic                 first_beat;
    logic                 last_beat;

    assign accept = (state == ST_IDLE) && start;
    assign beat   = (state == ST_RUN) && !data_stall;

    pe_tap_counter u_tap_counter (
        .clk         (clk),
        .rst         (rst),
        .clear       (accept || done),
        .advance     (beat),
        .last_group  (last_group),
        .tap_idx     (tap_idx),
        .weight_addr (weight_addr),
        .first_beat  (first_beat),
        .last_beat   (last_beat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_group <= '0;
            drain_cnt  <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                last_group <= last_group_of(cfg_groups);
            end
            if (beat && last_beat) begin
                drain_cnt <= DRAIN_INIT;
            end else if ((state == ST_DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        pe_ena     = 1'b0;
        pe_valid   = 1'b0;
        pe_op      = PE_OP_LOAD;
        out_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                pe_ena   = 1'b1;
                pe_valid = !data_stall;
                pe_op    = first_beat ? PE_OP_LOAD : PE_OP_ACC;
                if (beat && last_beat) begin
                    next_state = (PE_LAT == 0) ? ST_OUTPUT : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy   = 1'b1;
                pe_ena = 1'b1;
                if (drain_cnt == '0) begin
                    next_state = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                // PE enable stays low here so the finished tile is frozen on data_out.
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    done       = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

`ifdef PE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else if (accept) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && (perf_busy_cycles != '1)) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
            if ((state == ST_RUN) && data_stall && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pe_conv_ctrl.sv
// Self-checking bench for pe_conv_ctrl: scoreboarded PE beat stream, a tiny PE
// accumulator model for result checks, handshake/backpressure and reset scenarios.
module tb_pe_conv_ctrl;
    import pe_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [GRP_W-1:0]   cfg_groups;
    logic               data_stall;
    logic               busy;
    logic [TAP_W-1:0]   tap_idx;
    logic [WADDR_W-1:0] weight_addr;
    logic               pe_ena;
    logic               pe_valid;
    logic [1:0]         pe_op;
    logic               out_valid;
    logic               out_ready;
    logic               done;
`ifdef PE_CTRL_PERF_EN
    logic [31:0]        perf_busy_cycles;
    logic [31:0]        perf_stall_cycles;
`endif

    pe_conv_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_groups  (cfg_groups),
        .data_stall  (data_stall),
        .busy        (busy),
        .tap_idx     (tap_idx),
        .weight_addr (weight_addr),
        .pe_ena      (pe_ena),
        .pe_valid    (pe_valid),
        .pe_op       (pe_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .done        (done)
`ifdef PE_CTRL_PERF_EN
        ,
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TAP_W-1:0]   tap;
        logic [WADDR_W-1:0] addr;
        logic [1:0]         op;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];

    int checks   = 0;
    int failures = 0;

    int job_lat;
    int job_done_pulses;
    int job_stall_viol;
    int job_hold_viol;
    int job_done_viol;
    int job_waits;
    bit job_timeout;

    // PE stand-in: each weight line contributes a distinct partial product.
    logic [31:0] acc;

    function automatic logic [31:0] wval(input logic [WADDR_W-1:0] a);
        return 32'(a) * 32'd3 + 32'd1;
    endfunction

    function automatic logic [31:0] golden_sum(input int beats);
        logic [31:0] s = 32'd0;
        for (int a = 0; a < beats; a++) s += 32'(3 * a + 1);
        return s;
    endfunction

    always @(posedge clk) begin
        if (pe_ena && pe_valid)
            acc <= (pe_op == PE_OP_LOAD) ? wval(weight_addr) : acc + wval(weight_addr);
    end

    task automatic push_expected(input int groups);
        for (int b = 0; b < KTAPS * groups; b++)
            exp_q.push_back(beat_t'{tap: TAP_W'(b % KTAPS), addr: WADDR_W'(b),
                                    op: (b == 0) ? PE_OP_LOAD : PE_OP_ACC});
    endtask

    // Drives one job and records what the DUT did; the calling test judges it.
    task automatic run_job(input int groups, input int stall_at, input int stall_len,
                           input int ready_wait, input bit poke_start);
        int  cyc = 0;
        int  beats = 0;
        int  stalls_used = 0;
        bit  finished = 1'b0;
        job_lat = -1; job_done_pulses = 0; job_stall_viol = 0;
        job_hold_viol = 0; job_done_viol = 0; job_waits = 0;
        obs_q.delete();
        @(posedge clk); #1;
        start = 1'b1; cfg_groups = GRP_W'(groups); data_stall = 1'b0;
        out_ready = (ready_wait == 0);
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        while (!finished && cyc < 2000) begin
            data_stall = (beats == stall_at) && (stalls_used < stall_len);
            if (data_stall) stalls_used++;
            start = poke_start && out_valid;
            @(negedge clk);
            if (done) job_done_pulses++;
            if (data_stall && (pe_valid || tap_idx != TAP_W'(stall_at % KTAPS))) job_stall_viol++;
            if (pe_valid) begin
                obs_q.push_back(beat_t'{tap: tap_idx, addr: weight_addr, op: pe_op});
                beats++;
            end
            if (out_valid) begin
                if (job_lat < 0) job_lat = cyc;
                if (out_ready) begin
                    if (!done) job_done_viol++;
                    finished = 1'b1;
                end else begin
                    job_waits++;
                    if (pe_ena || !busy) job_hold_viol++;
                    if (done) job_done_viol++;
                end
            end
            @(posedge clk); #1;
            cyc++;
            out_ready = (job_waits >= ready_wait);
        end
        start = 1'b0; data_stall = 1'b0;
        job_timeout = !finished;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cfg_groups = '0; data_stall = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, pe_ena, pe_valid, out_valid, done} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, pe_ena, pe_valid, out_valid, done});
        end
        checks++;
        if (pe_op !== PE_OP_LOAD) begin
            failures++; $display("[TB] FAIL reset_op: got %0d expected 0", pe_op);
        end
        checks++;
        if (tap_idx !== '0 || weight_addr !== '0) begin
            failures++; $display("[TB] FAIL reset_counters: got tap=%0d addr=%0d expected 0/0", tap_idx, weight_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_group();
        beat_t e, o;
        push_expected(1);
        run_job(1, -1, 0, 0, 1'b0);
        checks++;
        if (job_timeout) begin failures++; $display("[TB] FAIL single_timeout: got no handshake expected one"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("[TB] FAIL single_beat: got none expected addr=%0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("[TB] FAIL single_beat: got tap=%0d addr=%0d op=%0d expected tap=%0d addr=%0d op=%0d",
                             o.tap, o.addr, o.op, e.tap, e.addr, e.op);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("[TB] FAIL single_extra_beats: got %0d expected 0", obs_q.size()); end
        checks++;
        if (job_lat != KTAPS + PE_LAT + 1) begin failures++; $display("[TB] FAIL single_latency: got %0d expected %0d", job_lat, KTAPS + PE_LAT + 1); end
        checks++;
        if (job_done_pulses != 1 || job_done_viol != 0) begin
            failures++; $display("[TB] FAIL single_done: got pulses=%0d viol=%0d expected 1/0", job_done_pulses, job_done_viol);
        end
        checks++;
        if (acc !== golden_sum(KTAPS)) begin failures++; $display("[TB] FAIL single_result: got %0d expected %0d", acc, golden_sum(KTAPS)); end
    endtask

    task automatic test_multi_group();
        beat_t e, o;
        push_expected(3);
        run_job(3, -1, 0, 0, 1'b0);
        checks++;
        if (job_timeout) begin failures++; $display("[TB] FAIL multi_timeout: got no handshake expected one"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("[TB] FAIL multi_beat: got none expected addr=%0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("[TB] FAIL multi_beat: got tap=%0d addr=%0d op=%0d expected tap=%0d addr=%0d op=%0d",
                             o.tap, o.addr, o.op, e.tap, e.addr, e.op);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("[TB] FAIL multi_extra_beats: got %0d expected 0", obs_q.size()); end
        checks++;
        if (job_lat != 3 * KTAPS + PE_LAT + 1) begin failures++; $display("[TB] FAIL multi_latency: got %0d expected %0d", job_lat, 3 * KTAPS + PE_LAT + 1); end
        checks++;
        if (acc !== golden_sum(3 * KTAPS)) begin failures++; $display("[TB] FAIL multi_result: got %0d expected %0d", acc, golden_sum(3 * KTAPS)); end
    endtask

    task automatic test_stall();
        beat_t e, o;
        push_expected(1);
        run_job(1, 4, 3, 0, 1'b0);
        checks++;
        if (job_timeout) begin failures++; $display("[TB] FAIL stall_timeout: got no handshake expected one"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("[TB] FAIL stall_beat: got none expected addr=%0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("[TB] FAIL stall_beat: got tap=%0d addr=%0d op=%0d expected tap=%0d addr=%0d op=%0d",
                             o.tap, o.addr, o.op, e.tap, e.addr, e.op);
                end
            end
        end
        checks++;
        if (job_stall_viol != 0) begin failures++; $display("[TB] FAIL stall_hold: got %0d bad stall cycles expected 0", job_stall_viol); end
        checks++;
        if (job_lat != KTAPS + PE_LAT + 1 + 3) begin failures++; $display("[TB] FAIL stall_latency: got %0d expected %0d", job_lat, KTAPS + PE_LAT + 4); end
        checks++;
        if (acc !== golden_sum(KTAPS)) begin failures++; $display("[TB] FAIL stall_result: got %0d expected %0d", acc, golden_sum(KTAPS)); end
    endtask

    task automatic test_ready_backpressure();
        run_job(2, -1, 0, 5, 1'b1);
        checks++;
        if (job_timeout) begin failures++; $display("[TB] FAIL ready_timeout: got no handshake expected one"); end
        checks++;
        if (obs_q.size() != 2 * KTAPS) begin failures++; $display("[TB] FAIL ready_beats: got %0d expected %0d", obs_q.size(), 2 * KTAPS); end
        checks++;
        if (job_waits != 5 || job_hold_viol != 0) begin
            failures++; $display("[TB] FAIL ready_hold: got waits=%0d viol=%0d expected 5/0", job_waits, job_hold_viol);
        end
        checks++;
        if (job_done_pulses != 1 || job_done_viol != 0) begin
            failures++; $display("[TB] FAIL ready_done: got pulses=%0d viol=%0d expected 1/0", job_done_pulses, job_done_viol);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ready_start_ignored: got busy=%0b expected 0", busy); end
        checks++;
        if (acc !== golden_sum(2 * KTAPS)) begin failures++; $display("[TB] FAIL ready_result: got %0d expected %0d", acc, golden_sum(2 * KTAPS)); end
    endtask

    task automatic test_zero_groups();
        beat_t e, o;
        push_expected(1);
        run_job(0, -1, 0, 0, 1'b0);
        checks++;
        if (job_timeout) begin failures++; $display("[TB] FAIL zero_timeout: got no handshake expected one"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("[TB] FAIL zero_beat: got none expected addr=%0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("[TB] FAIL zero_beat: got tap=%0d addr=%0d op=%0d expected tap=%0d addr=%0d op=%0d",
                             o.tap, o.addr, o.op, e.tap, e.addr, e.op);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("[TB] FAIL zero_extra_beats: got %0d expected 0", obs_q.size()); end
        checks++;
        if (job_lat != KTAPS + PE_LAT + 1) begin failures++; $display("[TB] FAIL zero_latency: got %0d expected %0d", job_lat, KTAPS + PE_LAT + 1); end
    endtask

    task automatic test_reset_mid_job();
        @(posedge clk); #1;
        start = 1'b1; cfg_groups = GRP_W'(2); out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (tap_idx !== TAP_W'(5) || weight_addr !== WADDR_W'(5) || busy !== 1'b1) begin
            failures++; $display("[TB] FAIL midjob_progress: got tap=%0d addr=%0d busy=%0b expected 5/5/1", tap_idx, weight_addr, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, pe_ena, pe_valid, out_valid, done, pe_op} !== 7'b0 || tap_idx !== '0 || weight_addr !== '0) begin
            failures++;
            $display("[TB] FAIL midjob_async_reset: got flags=%b op=%0d tap=%0d addr=%0d expected all 0",
                     {busy, pe_ena, pe_valid, out_valid, done}, pe_op, tap_idx, weight_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_job(1, -1, 0, 0, 1'b0);
        checks++;
        if (job_timeout || job_lat != KTAPS + PE_LAT + 1) begin
            failures++; $display("[TB] FAIL postreset_latency: got %0d expected %0d", job_lat, KTAPS + PE_LAT + 1);
        end
        checks++;
        if (acc !== golden_sum(KTAPS)) begin failures++; $display("[TB] FAIL postreset_result: got %0d expected %0d", acc, golden_sum(KTAPS)); end
    endtask

`ifdef PE_CTRL_PERF_EN
    task automatic test_perf();
        run_job(2, 3, 4, 2, 1'b0);
        checks++;
        if (perf_stall_cycles !== 32'd4) begin failures++; $display("[TB] FAIL perf_stall: got %0d expected 4", perf_stall_cycles); end
        checks++;
        if (perf_busy_cycles !== 32'(2 * KTAPS + 4 + PE_LAT + 1 + 2)) begin
            failures++; $display("[TB] FAIL perf_busy: got %0d expected %0d", perf_busy_cycles, 2 * KTAPS + 4 + PE_LAT + 1 + 2);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_group();
        test_multi_group();
        test_stall();
        test_ready_backpressure();
        test_zero_groups();
        test_reset_mid_job();
`ifdef PE_CTRL_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
